// File: rtl/ram_port_ctrl.sv
// Request/response front end for a single-port synchronous RAM with a shared tri-state data bus.
// Optional burst support (req_len) is enabled by defining RAM_PORT_CTRL_BURST_EN.
module ram_port_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef RAM_PORT_CTRL_BURST_EN
  input  logic [1:0]            req_len,
`endif
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, TURN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            len_in;
  logic [1:0]            beats_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cap_q;
  logic                  ready_c;
  logic                  accept;
  logic                  last_beat;

`ifdef RAM_PORT_CTRL_BURST_EN
  assign len_in = req_len;
`else
  assign len_in = '0;
`endif

  assign last_beat = (beats_q == 2'd0);
  assign req_ready = ready_c & ~rst;
  assign accept    = req_valid & req_ready;

  // Only a write beat drives the bus; every other state leaves it to the RAM or floating.
  assign ram_data = (ram_we && !ram_oe) ? wdata_q : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    ram_cs  = 1'b0;
    ram_we  = 1'b0;
    ram_oe  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (accept) state_d = req_write ? WR : RD;
      end
      WR: begin
        ram_cs  = 1'b1;
        ram_we  = 1'b1;
        ready_c = last_beat;
        if (!last_beat)  state_d = WR;
        else if (accept) state_d = req_write ? WR : RD;
        else             state_d = IDLE;
      end
      RD: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        if (last_beat) state_d = RD_CAP;
      end
      // RAM keeps driving the last word here; bus is released in TURN.
      RD_CAP: begin
        ram_oe  = 1'b1;
        state_d = TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cap_q marks that the RAM sampled a read address on the previous edge,
  // so its output is on the bus and gets captured on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      wdata_q   <= '0;
      beats_q   <= '0;
      cap_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      cap_q     <= (state_q == RD);
      rsp_valid <= cap_q;
      if (cap_q) rsp_data <= ram_data;
      if (accept) begin
        ram_addr <= req_addr;
        wdata_q  <= req_wdata;
        beats_q  <= len_in;
      end else if ((state_q == WR || state_q == RD) && !last_beat) begin
        ram_addr <= ram_addr + ADDR_WIDTH'(1);
        wdata_q  <= req_wdata;
        beats_q  <= beats_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural single-port synchronous RAM on the bus.
// Burst checks compile in when RAM_PORT_CTRL_BURST_EN is defined.
module tb_ram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
`ifdef RAM_PORT_CTRL_BURST_EN
  logic [1:0]  req_len;
`endif
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [14:0] ram_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  wire  [15:0] ram_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_ctrl #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RAM_PORT_CTRL_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_addr(ram_addr),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_data(ram_data)
  );

  logic [15:0] mem [0:32767];
  logic [15:0] ram_q = '0;

  always @(posedge clk) begin
    if (ram_cs && ram_we)  mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
  end
  assign ram_data = ram_oe ? ram_q : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [14:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    chk("wr_cs", ram_cs, 1); chk("wr_we", ram_we, 1); chk("wr_oe", ram_oe, 0);
    chk("wr_addr", ram_addr, a);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_idle_cs", ram_cs, 0);
  endtask

  task automatic do_read(input logic [14:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    chk("rd_cs", ram_cs, 1); chk("rd_oe", ram_oe, 1); chk("rd_we", ram_we, 0);
    chk("rd_addr", ram_addr, a); chk("rd_ready", req_ready, 0); chk("rd_v0", rsp_valid, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rdcap_v", rsp_valid, 0); chk("rdcap_cs", ram_cs, 0); chk("rdcap_ready", req_ready, 0);
    @(negedge clk);
    chk("rd_rspv", rsp_valid, 1); chk("rd_data", rsp_data, d);
    chk("turn_cs", ram_cs, 0); chk("turn_oe", ram_oe, 0); chk("turn_ready", req_ready, 0);
    @(negedge clk);
    chk("rd_after_v", rsp_valid, 0); chk("rd_after_ready", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef RAM_PORT_CTRL_BURST_EN
    req_len = 2'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0); chk("rst_rspv", rsp_valid, 0); chk("rst_data", rsp_data, 0);
    chk("rst_addr", ram_addr, 0); chk("rst_cs", ram_cs, 0); chk("rst_we", ram_we, 0);
    chk("rst_oe", ram_oe, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // Write then read back at 0x1FFF
    do_write(15'h1FFF, 16'hA5A5);
    do_read(15'h1FFF, 16'hA5A5);

    // Four back-to-back writes
    req_valid = 1'b1; req_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 15'h3FFC + 15'(i); req_wdata = 16'h1111 * 16'(i + 1);
      @(negedge clk);
      chk("b2b_cs", ram_cs, 1); chk("b2b_we", ram_we, 1); chk("b2b_ready", req_ready, 1);
      chk("b2b_addr", ram_addr, 15'h3FFC + 15'(i));
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle_cs", ram_cs, 0); chk("b2b_idle_we", ram_we, 0);
    do_read(15'h3FFE, 16'h3333);
    do_read(15'h3FFF, 16'h4444);

    // Read then write to the same address: one TURN cycle separates them
    do_write(15'h5FFC, 16'h1234);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h5FFC;
    @(negedge clk);
    chk("rw_rd_cs", ram_cs, 1);
    req_write = 1'b1; req_wdata = 16'hBEEF;
    @(negedge clk);
    chk("rw_cap_ready", req_ready, 0); chk("rw_cap_we", ram_we, 0);
    @(negedge clk);
    chk("rw_turn_cs", ram_cs, 0); chk("rw_turn_oe", ram_oe, 0); chk("rw_turn_we", ram_we, 0);
    chk("rw_rspv", rsp_valid, 1); chk("rw_data", rsp_data, 16'h1234);
    @(negedge clk);
    chk("rw_idle_ready", req_ready, 1); chk("rw_idle_we", ram_we, 0);
    @(negedge clk);
    chk("rw_wr_cs", ram_cs, 1); chk("rw_wr_we", ram_we, 1); chk("rw_wr_oe", ram_oe, 0);
    chk("rw_wr_addr", ram_addr, 15'h5FFC);
    req_valid = 1'b0;
    @(negedge clk);
    do_read(15'h5FFC, 16'hBEEF);

    // Reset the cycle after a read is accepted
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1FFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_cs_pre", ram_cs, 1);
    rst = 1'b1;
    #1;
    chk("mid_cs", ram_cs, 0); chk("mid_oe", ram_oe, 0); chk("mid_we", ram_we, 0);
    chk("mid_addr", ram_addr, 0); chk("mid_data", rsp_data, 0); chk("mid_rspv", rsp_valid, 0);
    chk("mid_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rspv", rsp_valid, 0); chk("mid_ready_after", req_ready, 1);
    end

`ifdef RAM_PORT_CTRL_BURST_EN
    begin
      logic [14:0] exp_a [0:3];
      exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000; exp_a[3] = 15'h0001;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h7FFE; req_len = 2'd3;
      for (int i = 0; i < 4; i++) begin
        req_wdata = 16'(i + 1);
        @(negedge clk);
        chk("bw_addr", ram_addr, exp_a[i]); chk("bw_we", ram_we, 1);
        chk("bw_ready", req_ready, (i == 3) ? 1 : 0);
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("bw_idle_cs", ram_cs, 0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h7FFE;
      @(negedge clk);
      req_valid = 1'b0; req_len = 2'd0;
      chk("br_addr0", ram_addr, 15'h7FFE); chk("br_v0", rsp_valid, 0);
      for (int i = 1; i < 4; i++) begin
        @(negedge clk);
        chk("br_addr", ram_addr, exp_a[i]); chk("br_cs", ram_cs, 1);
        chk("br_v", rsp_valid, (i >= 2) ? 1 : 0);
        if (i >= 2) chk("br_data", rsp_data, 32'(i - 1));
      end
      @(negedge clk);
      chk("br_cap_v", rsp_valid, 1); chk("br_cap_d", rsp_data, 3); chk("br_cap_cs", ram_cs, 0);
      @(negedge clk);
      chk("br_turn_v", rsp_valid, 1); chk("br_turn_d", rsp_data, 4); chk("br_turn_oe", ram_oe, 0);
      @(negedge clk);
      chk("br_end_v", rsp_valid, 0); chk("br_end_ready", req_ready, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
